pll_ce_gen: RTL and testbench

PLL_CE_GEN -- requirements
Module: pll_ce_gen

---
 rtl/pll_ce_pkg.sv | 20 ++
 rtl/pll_ce_acc.sv | 38 +++
 rtl/pll_ce_gen.sv | 107 ++++++++++
 tb/tb_pll_ce_gen.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_ce_pkg.sv
// Shared definitions for the PLL-qualified clock-enable generator: FSM encoding,
// default parameter values and the channel-slice helper.
package pll_ce_pkg;

    typedef enum logic [1:0] {
        StWaitLock = 2'd0,
        StSettle   = 2'd1,
        StRun      = 2'd2
    } state_e;

    localparam int unsigned DefNumCh      = 3;
    localparam int unsigned DefAccW       = 24;
    localparam int unsigned DefLockStable = 1024;

    // Low bit of channel ch inside a flat bus of w-bit slices.
    function automatic int unsigned ch_lo(input int unsigned ch, input int unsigned w);
        return ch * w;
    endfunction

endpackage

// File: rtl/pll_ce_acc.sv
// One clock-enable channel: phase accumulator whose carry out becomes a
// single-cycle registered strobe.
module pll_ce_acc
    import pll_ce_pkg::*;
#(
    parameter int unsigned ACC_W = DefAccW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             clear,
    input  logic             en,
    input  logic [ACC_W-1:0] inc,
    output logic             ce
);

    logic [ACC_W-1:0] acc_q;
    logic             ce_q;
    logic [ACC_W:0]   sum;

    assign sum = {1'b0, acc_q} + {1'b0, inc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            ce_q  <= 1'b0;
        end else if (run && en && !clear) begin
            acc_q <= sum[ACC_W-1:0];
            ce_q  <= sum[ACC_W];
        end else begin
            acc_q <= '0;
            ce_q  <= 1'b0;
        end
    end

    assign ce = ce_q;

endmodule

// File: rtl/pll_ce_gen.sv
// Lock-qualified fractional clock-enable generator: synchronizes PLL lock, waits for
// a stable lock period, then runs NUM_CH phase accumulators.
module pll_ce_gen
    import pll_ce_pkg::*;
#(
    parameter int unsigned NUM_CH      = DefNumCh,
    parameter int unsigned ACC_W       = DefAccW,
    parameter int unsigned LOCK_STABLE = DefLockStable
) (
    input  logic                    refclk,
    input  logic                    rst_n,
    input  logic                    locked,
    input  logic [NUM_CH*ACC_W-1:0] inc,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic                    realign,
    input  logic                    clr_status,
    output logic [NUM_CH-1:0]       ce,
    output logic                    ready,
    output logic                    lock_lost
);

    localparam int unsigned CntW = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;

    logic [1:0]      sync_q;
    logic            lock_s;
    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            ready_q;
    logic            lock_lost_q;
    logic            run_en;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], locked};
        end
    end

    assign lock_s = sync_q[1];

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StWaitLock;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            // Clear first so a coincident loss of lock below overrides it.
            if (clr_status) begin
                lock_lost_q <= 1'b0;
            end
            case (state_q)
                StWaitLock: begin
                    if (lock_s) begin
                        state_q <= StSettle;
                        cnt_q   <= '0;
                    end
                end
                StSettle: begin
                    if (!lock_s) begin
                        state_q <= StWaitLock;
                        cnt_q   <= '0;
                    end else if (cnt_q == CntW'(LOCK_STABLE - 1)) begin
                        state_q <= StRun;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StRun: begin
                    if (!lock_s) begin
                        state_q     <= StWaitLock;
                        lock_lost_q <= 1'b1;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StWaitLock;
                end
            endcase
        end
    end

    // Accumulate only when staying in RUN, so no strobe lands on the edge ready falls.
    assign run_en = (state_q == StRun) && lock_s;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pll_ce_acc #(
            .ACC_W(ACC_W)
        ) u_acc (
            .clk  (refclk),
            .rst_n(rst_n),
            .run  (run_en),
            .clear(realign),
            .en   (ch_en[i]),
            .inc  (inc[ch_lo(i, ACC_W) +: ACC_W]),
            .ce   (ce[i])
        );
    end

    assign ready     = ready_q;
    assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_pll_ce_gen.sv
// Directed bench for pll_ce_gen: lock qualification, integer/fractional divide,
// realign, lock loss, sticky status and asynchronous reset.
module tb_pll_ce_gen;

    localparam int unsigned NumCh = 3;
    localparam int unsigned AccW  = 24;

    logic                  refclk = 1'b0;
    logic                  rst_n;
    logic                  locked;
    logic [NumCh*AccW-1:0] inc;
    logic [NumCh-1:0]      ch_en;
    logic                  realign;
    logic                  clr_status;
    logic [NumCh-1:0]      ce;
    logic                  ready;
    logic                  lock_lost;

    int checks   = 0;
    int failures = 0;

    pll_ce_gen #(
        .NUM_CH     (NumCh),
        .ACC_W      (AccW),
        .LOCK_STABLE(16)
    ) dut (
        .refclk    (refclk),
        .rst_n     (rst_n),
        .locked    (locked),
        .inc       (inc),
        .ch_en     (ch_en),
        .realign   (realign),
        .clr_status(clr_status),
        .ce        (ce),
        .ready     (ready),
        .lock_lost (lock_lost)
    );

    always #5 refclk = ~refclk;

    typedef struct {
        logic [AccW-1:0] inc0;
        logic [AccW-1:0] inc1;
        logic [AccW-1:0] inc2;
        logic [2:0]      en;
        int              win;
        int              cnt0, cnt1, cnt2;
        int              first0, first1, first2;
    } vec_t;

    vec_t vecs[4];

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Returns the number of edges until ready, or 0 on timeout.
    task automatic wait_ready(output int n);
        n = 0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (ready) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int ever;
        int cnt[3];
        int first[3];
        int pulses, prev_k, min_int, max_int, diff, fell_k, bad;
        logic [2:0] exp_ce;

        vecs[0] = '{24'h400000, 24'h800000, 24'h000000, 3'b111, 16, 4, 8, 0, 4, 2, 0};
        vecs[1] = '{24'hC00000, 24'h200000, 24'hFFFFFF, 3'b111, 16, 12, 2, 15, 2, 8, 2};
        vecs[2] = '{24'h400000, 24'h400000, 24'h400000, 3'b010, 16, 0, 4, 0, 0, 4, 0};
        vecs[3] = '{24'h000001, 24'h800000, 24'h400000, 3'b101, 16, 0, 0, 4, 0, 0, 4};

        rst_n      = 1'b0;
        locked     = 1'b0;
        inc        = '0;
        ch_en      = '0;
        realign    = 1'b0;
        clr_status = 1'b0;
        #23;
        check("rst_ce", 32'(ce), 0);
        check("rst_ready", 32'(ready), 0);
        check("rst_lock_lost", 32'(lock_lost), 0);
        rst_n = 1'b1;
        repeat (3) tick();

        // Lock drops partway through settling: never reaches RUN.
        inc   = {24'h000000, 24'h800000, 24'h400000};
        ch_en = 3'b011;
        locked = 1'b1;
        ever = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            ever |= int'(ready);
        end
        locked = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            ever |= int'(ready);
        end
        check("settle_abort_ready", 32'(ever), 0);

        // 2 sync + 16 settle + 1 edges to ready.
        locked = 1'b1;
        wait_ready(n);
        check("lock_to_ready_edges", 32'(n), 19);

        // RUN cycle 1 is the first cycle ready is high.
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) tick();
            exp_ce[0] = (c >= 5) && ((c - 5) % 4 == 0);
            exp_ce[1] = (c >= 3) && ((c - 3) % 2 == 0);
            exp_ce[2] = 1'b0;
            check($sformatf("int_div_cycle%0d", c), 32'(ce), 32'(exp_ce));
        end

        for (int v = 0; v < 4; v++) begin
            inc     = {vecs[v].inc2, vecs[v].inc1, vecs[v].inc0};
            ch_en   = vecs[v].en;
            realign = 1'b1;
            tick();
            realign = 1'b0;
            check($sformatf("v%0d_realign_ce", v), 32'(ce), 0);
            for (int ch = 0; ch < 3; ch++) begin
                cnt[ch]   = 0;
                first[ch] = 0;
            end
            for (int k = 1; k <= vecs[v].win; k++) begin
                tick();
                for (int ch = 0; ch < 3; ch++) begin
                    if (ce[ch]) begin
                        cnt[ch]++;
                        if (first[ch] == 0) first[ch] = k;
                    end
                end
            end
            check($sformatf("v%0d_cnt0", v), 32'(cnt[0]), 32'(vecs[v].cnt0));
            check($sformatf("v%0d_cnt1", v), 32'(cnt[1]), 32'(vecs[v].cnt1));
            check($sformatf("v%0d_cnt2", v), 32'(cnt[2]), 32'(vecs[v].cnt2));
            check($sformatf("v%0d_first0", v), 32'(first[0]), 32'(vecs[v].first0));
            check($sformatf("v%0d_first1", v), 32'(first[1]), 32'(vecs[v].first1));
            check($sformatf("v%0d_first2", v), 32'(first[2]), 32'(vecs[v].first2));
        end

        // Increment change mid-flight keeps the accumulated phase.
        inc     = {24'h0, 24'h0, 24'h400000};
        ch_en   = 3'b001;
        realign = 1'b1;
        tick();
        realign = 1'b0;
        tick();
        tick();
        check("inc_change_pre", 32'(ce[0]), 0);
        inc = {24'h0, 24'h0, 24'h800000};
        tick();
        check("inc_change_carry", 32'(ce[0]), 1);

        // Fractional divide by ~6.
        inc     = {24'd2796203, 24'h0, 24'h0};
        ch_en   = 3'b100;
        realign = 1'b1;
        tick();
        realign = 1'b0;
        pulses  = 0;
        prev_k  = -1;
        min_int = 1000000;
        max_int = 0;
        for (int k = 1; k <= 6000; k++) begin
            tick();
            if (ce[2]) begin
                pulses++;
                if (prev_k >= 0) begin
                    if (k - prev_k < min_int) min_int = k - prev_k;
                    if (k - prev_k > max_int) max_int = k - prev_k;
                end
                prev_k = k;
            end
        end
        check_rng("frac_pulses", pulses, 999, 1001);
        check_rng("frac_min_interval", min_int, 5, 6);
        check_rng("frac_max_interval", max_int, 5, 6);

        // Skew the two channels, then realign them.
        inc     = {24'h0, 24'h800000, 24'h400000};
        ch_en   = 3'b011;
        realign = 1'b1;
        tick();
        realign = 1'b0;
        tick();
        inc = {24'h0, 24'h400000, 24'h400000};
        repeat (5) tick();
        realign = 1'b1;
        tick();
        realign = 1'b0;
        check("realign_next_ce", 32'(ce), 0);
        diff = 0;
        cnt[0] = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (ce[0] != ce[1]) diff++;
            if (ce[0]) cnt[0]++;
        end
        check("realign_coincident_diffs", 32'(diff), 0);
        check("realign_ce0_count", 32'(cnt[0]), 5);

        // Lock loss at maximum strobe rate.
        inc   = {24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF};
        ch_en = 3'b111;
        repeat (3) tick();
        locked = 1'b0;
        fell_k = 0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (!ready) begin
                fell_k = k;
                break;
            end
        end
        check_rng("lockloss_ready_fall", fell_k, 1, 3);
        check("lockloss_ce_at_fall", 32'(ce), 0);
        check("lockloss_flag", 32'(lock_lost), 1);
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (ce != 3'b000) bad++;
        end
        check("lockloss_ce_stays_0", 32'(bad), 0);

        locked = 1'b1;
        wait_ready(n);
        check_rng("relock_ready", n, 1, 60);
        check("lock_lost_sticky", 32'(lock_lost), 1);
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        check("clr_status_clears", 32'(lock_lost), 0);
        locked = 1'b0;
        tick();
        tick();
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        check("set_beats_clear", 32'(lock_lost), 1);
        check("set_beats_clear_ready", 32'(ready), 0);

        // Asynchronous reset between edges while ce0 is high.
        inc   = {24'h0, 24'h0, 24'hFFFFFF};
        ch_en = 3'b001;
        locked = 1'b1;
        wait_ready(n);
        check_rng("reset_test_ready", n, 1, 60);
        n = 0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (ce[0]) begin
                n = k;
                break;
            end
        end
        check_rng("reset_test_ce0_seen", n, 1, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_ce", 32'(ce), 0);
        check("async_rst_ready", 32'(ready), 0);
        check("async_rst_lock_lost", 32'(lock_lost), 0);
        #10;
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", 32'(ready), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
